// File: rtl/tnn_pkg.sv
// Shared definitions for the TNN class-vote block: FSM state encoding and
// default lane/counter sizing.
package tnn_pkg;

  localparam int DEF_NUM_CLASSES = 6;
  localparam int DEF_CNT_W       = 4;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } vote_state_e;

endpackage

// File: rtl/tnn_sat_cnt.sv
// Saturating vote counter for one class lane, with synchronous clear.
// The count sticks at all-ones instead of wrapping.
module tnn_sat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear has priority over increment; increment stops at full scale.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tnn_class_vote.sv
// TNN class vote: accumulates per-class comparator-neuron votes over the
// beats of a sample, scans the counters for the arg-max and presents the
// winning class on a valid/ready output.
// Optional feature macro: TNN_VOTE_SCORE_EN adds the out_score port.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACC   | accept beats, count votes; last beat starts the scan
//   SCAN  | one class per cycle, keep strictly-greater maximum
//   OUT   | hold result until the consumer takes it, then clear votes
module tnn_class_vote
  import tnn_pkg::*;
#(
  parameter  int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter  int CNT_W       = DEF_CNT_W,
  localparam int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_CLASSES-1:0] in_bits,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_class
`ifdef TNN_VOTE_SCORE_EN
  ,
  output logic [CNT_W-1:0]       out_score
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  vote_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt [NUM_CLASSES];
  logic [CNT_W-1:0] cur_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;

  logic accept;
  logic scan_start;
  logic out_done;
  logic cnt_clr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode; reset forces both readies/valids low.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    scan_start = 1'b0;
    out_done   = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept && in_last) begin
          scan_start = 1'b1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (idx == LAST_IDX) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = !rst;
        if (out_ready && !rst) begin
          out_done = 1'b1;
          state_d  = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  assign cnt_clr = rst || out_done;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    tnn_sat_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .clr   (cnt_clr),
      .inc   (accept && in_bits[k]),
      .count (cnt[k])
    );
  end

  assign cur_cnt = cnt[idx];

  // Scan datapath: restart at class 0 on the last beat, then walk the lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (scan_start) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (state_q == SCAN) begin
      if (cur_cnt > best_cnt) begin
        best_idx <= idx;
        best_cnt <= cur_cnt;
      end
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  assign out_class = best_idx;
`ifdef TNN_VOTE_SCORE_EN
  assign out_score = best_cnt;
`endif

endmodule

// File: tb/tb_tnn_class_vote.sv
// Directed self-checking bench for tnn_class_vote (default 6 classes,
// 4-bit counters). Score checks are built only with TNN_VOTE_SCORE_EN.
module tb_tnn_class_vote;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_bits;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
`ifdef TNN_VOTE_SCORE_EN
  logic [3:0] out_score;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  tnn_class_vote dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class)
`ifdef TNN_VOTE_SCORE_EN
    ,
    .out_score (out_score)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] bits, input logic last);
    in_valid = 1'b1;
    in_bits  = bits;
    in_last  = last;
    check("in_ready_acc", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bits  = '0;
  endtask

  // Counts edges from the last-beat edge until out_valid shows, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic result(input string tag, input logic [2:0] cls, input logic [3:0] score);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_class"}, out_class, cls);
`ifdef TNN_VOTE_SCORE_EN
    check({tag, "_score"}, out_score, score);
`else
    if (score == 4'hf) begin
      // score only observable with the score port built
    end
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_ready_after"}, in_ready, 1'b1);
    check({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bits = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_class", out_class, 3'd0);
`ifdef TNN_VOTE_SCORE_EN
    check("rst_out_score", out_score, 4'd0);
`endif
    rst = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1'b1);

    // Three beats, lane 2 wins; upstream keeps pushing lane-1 bits during SCAN.
    beat(6'b000100, 1'b0);
    beat(6'b000110, 1'b0);
    beat(6'b000100, 1'b1);
    check("scan_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_bits = 6'b000010;
    wait_out(lat);
    result("basic", 3'd2, 4'd3);

    // Tie between lanes 1 and 5: lowest index wins.
    beat(6'b100010, 1'b0);
    beat(6'b100010, 1'b1);
    wait_out(lat);
    result("tie", 3'd1, 4'd2);

    // Saturation at 15 after 20 votes.
    for (int i = 0; i < 19; i++) beat(6'b000001, 1'b0);
    beat(6'b000001, 1'b1);
    wait_out(lat);
    result("sat", 3'd0, 4'd15);

    // Backpressure in OUT, with ignored input traffic.
    beat(6'b001000, 1'b1);
    wait_out(lat);
    in_valid = 1'b1; in_bits = 6'b111111; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_class", out_class, 3'd3);
      check("bp_in_ready", in_ready, 1'b0);
      step();
    end
    in_last = 1'b0;
    result("bp", 3'd3, 4'd1);

    // All-zero single beat: counters must have cleared after the handshake.
    beat(6'b000000, 1'b1);
    wait_out(lat);
    result("zero", 3'd0, 4'd0);

    // Reset during SCAN drops the sample.
    beat(6'b000001, 1'b1);
    step(); step();
    rst = 1'b1;
    step();
    check("rst_scan_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("rst_scan_no_valid", out_valid, 1'b0);
      step();
    end
    beat(6'b010000, 1'b1);
    wait_out(lat);
    result("after_scan_rst", 3'd4, 4'd1);

    // Reset mid-ACC drops the partial votes.
    beat(6'b000001, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    beat(6'b000010, 1'b1);
    wait_out(lat);
    result("after_acc_rst", 3'd1, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tnn_class_vote.md
TNN_CLASS_VOTE -- requirements
Module: tnn_class_vote

Interface
REQ-001 Parameter NUM_CLASSES, default 6: number of class lanes, one comparator-neuron bit per class per beat.
REQ-002 Parameter CNT_W, default 4: per-class vote counter width, saturating at 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  beat of neuron bits is present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_bits  input  NUM_CLASSES  bit k = 1-bit comparator output (sum >= threshold) for class k.
REQ-008 in_last  input  1  marks the final beat of a sample.
REQ-009 out_valid  output  1  classification result is present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_class  output  clog2(NUM_CLASSES)  winning class index.
REQ-012 out_score  output  CNT_W  vote count of the winner (present only with TNN_VOTE_SCORE_EN).

Function
REQ-013 The block SHALL implement FSM states ACC, SCAN and OUT.
REQ-014 ACC: in_ready=1, out_valid=0; on an in_valid&&in_ready handshake, cnt[k] SHALL increment for each k with in_bits[k]=1, saturating at 2^CNT_W-1 with no wrap.
REQ-015 ACC, handshake with in_last=1: the bits of that beat SHALL be counted, then the FSM SHALL go to SCAN with idx=0, best_idx=0, best_cnt=0.
REQ-016 SCAN: in_ready=0; one class per cycle; if cnt[idx] > best_cnt then best_idx<=idx, best_cnt<=cnt[idx]; strict compare, so on a tie the lowest index wins.
REQ-017 SCAN SHALL run exactly NUM_CLASSES cycles, then go to OUT.
REQ-018 Latency: last beat accepted at edge E; out_valid SHALL first be high in the cycle following edge E+NUM_CLASSES.
REQ-019 OUT: out_valid=1; out_class=best_idx and out_score=best_cnt SHALL be held stable until out_valid&&out_ready.
REQ-020 OUT handshake: all cnt SHALL clear to 0, and the FSM SHALL return to ACC with in_ready=1 the next cycle.
REQ-021 A sample with all bits 0 SHALL produce out_class=0, out_score=0.
REQ-022 in_last on a single-beat sample SHALL be legal.
REQ-023 In SCAN and OUT, in_valid SHALL be ignored; the upstream holds data per valid/ready rules.

Reset
REQ-024 When rst=1, the FSM SHALL enter ACC; all cnt, idx, best_idx and best_cnt SHALL be 0; out_valid=0, in_ready=0 in the reset cycle, and 1 from the first cycle after rst deasserts.
REQ-025 rst asserted mid-ACC, mid-SCAN or in OUT SHALL discard the partial sample; no result is emitted for it.
REQ-026 out_class and out_score SHALL reset to 0.

Configuration
REQ-027 Macro TNN_VOTE_SCORE_EN defined: the out_score port exists and carries best_cnt.
REQ-028 TNN_VOTE_SCORE_EN undefined: the out_score port is absent; best_cnt stays internal; all other behaviour and timing are identical.

Structure
REQ-029 A shared package tnn_pkg SHALL hold the FSM state enum (ACC, SCAN, OUT) and the default constants NUM_CLASSES=6 and CNT_W=4.
REQ-030 A single sub-module tnn_sat_cnt (CNT_W-bit saturating increment with synchronous clear) SHALL be instantiated once per class.

Verification
REQ-031 Three beats in_bits=6'b000100, 6'b000110, 6'b000100 (last) -> out_class=2, out_score=3, out_valid rises 6 cycles after the last-beat edge.
REQ-032 Tie: two beats in_bits=6'b100010 (last on beat 2) -> out_class=1, out_score=2.
REQ-033 Saturation: 20 beats in_bits=6'b000001 -> out_class=0, out_score=15.
REQ-034 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid and out_class stay stable and in_ready=0; on release, one handshake, then in_ready=1 the next cycle and cnt=0.
REQ-035 rst=1 during SCAN of a sample -> no out_valid; the next sample 6'b010000 (last) -> out_class=4, out_score=1.
REQ-036 Build without TNN_VOTE_SCORE_EN -> REQ-031 to REQ-035 class results and timing are unchanged.
